capture_framer: RTL and testbench

CAPTURE_FRAMER -- requirements
Module: capture_framer

---
 rtl/capture_pkg.sv | 11 +
 rtl/capture_payload_ram.sv | 19 +
 rtl/capture_framer.sv | 128 ++++++++++++
 tb/tb_capture_framer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared constants and state encoding for the USB capture framer
package capture_pkg;
  localparam int SOP_BIT = 0;
  localparam int EOP_BIT = 1;
  localparam int DIR_BIT = 2;
  localparam int CRCERR_BIT = 3;
  localparam int TRUNC_BIT = 7;
  localparam int HDR_LEN = 12;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  typedef enum logic [2:0] {IDLE, COLLECT, HDR, PAY, CSUM} state_t;
endpackage

// File: rtl/capture_payload_ram.sv
// capture_payload_ram: DEPTH x 8 simple dual-port RAM, synchronous read with 1-cycle latency
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port (rdata follows raddr one clock later).
module capture_payload_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/capture_framer.sv
// capture_framer: collects SOP..EOP byte records and emits SYNC/header/payload/checksum frames
// Ports: clk, rst_n (async, active-low); in_* capture byte stream (valid/ready);
//        out_* frame byte stream (valid/ready) with sop/eop markers; drop_count, busy status.
module capture_framer
  import capture_pkg::*;
#(
  parameter int PAYLOAD_DEPTH = 256,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic [63:0] in_timestamp,
  input  logic [7:0]  in_flags,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [15:0] drop_count,
  output logic        busy
);
  localparam int AW = $clog2(PAYLOAD_DEPTH);
  localparam logic [15:0] DEPTH16 = 16'(PAYLOAD_DEPTH);
  state_t state;
  logic [63:0] ts, ts_b;
  logic [6:0] flg;
  logic trunc;
  logic [15:0] len, cnt;
  logic [7:0] csum, hdr_byte, rdata;
  logic [3:0] idx;
  logic sop, eop, in_xfer, adv, drop, go_hdr, we, unused;
  logic [AW-1:0] waddr, raddr;
  assign sop = in_flags[SOP_BIT];
  assign eop = in_flags[EOP_BIT];
  assign unused = in_flags[7];
  assign in_xfer = in_valid && in_ready;
  assign adv = !out_valid || out_ready;
  // a non-SOP byte in IDLE and an SOP byte in COLLECT are both drops
  assign drop = in_xfer && ((state == IDLE) != sop);
  assign go_hdr = in_xfer && eop && (sop || state == COLLECT);
  assign we = in_xfer && (sop || (state == COLLECT && len < DEPTH16));
  assign waddr = sop ? '0 : len[AW-1:0];
  // read address runs one ahead when a payload byte is consumed so rdata is always the next byte
  assign raddr = (state == PAY && adv) ? AW'(cnt + 16'd1) : cnt[AW-1:0];
  assign busy = state != IDLE;
  always_comb begin
    ts_b = ts >> {idx - 4'd2, 3'd0};
    hdr_byte = idx == 4'd0 ? SYNC_BYTE :
               idx == 4'd1 ? {trunc, flg} :
               idx == 4'd10 ? len[7:0] :
               idx == 4'd11 ? len[15:8] : ts_b[7:0];
  end
  capture_payload_ram #(.DEPTH(PAYLOAD_DEPTH)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(in_data), .raddr(raddr), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_data <= '0;
      drop_count <= '0;
      len <= '0;
      csum <= '0;
      cnt <= '0;
      idx <= '0;
      ts <= '0;
      flg <= '0;
      trunc <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE, COLLECT: begin
          if (drop) drop_count <= drop_count + 16'(drop_count != 16'hFFFF);
          if (in_xfer && sop) begin
            ts <= in_timestamp;
            flg <= in_flags[6:0];
            trunc <= 1'b0;
            len <= 16'd1;
          end else if (in_xfer && state == COLLECT) begin
            if (len < DEPTH16) len <= len + 16'd1;
            else trunc <= 1'b1;
          end
          state <= go_hdr ? HDR : (in_xfer && sop) ? COLLECT : state;
          in_ready <= !go_hdr;
          idx <= '0;
          cnt <= '0;
          csum <= '0;
        end
        HDR: if (adv) begin
          out_data <= hdr_byte;
          out_valid <= 1'b1;
          out_sop <= idx == 4'd0;
          out_eop <= 1'b0;
          if (idx != 4'd0) csum <= csum ^ hdr_byte;
          idx <= idx + 4'd1;
          if (idx == 4'(HDR_LEN - 1)) state <= PAY;
        end
        PAY: if (adv) begin
          out_data <= rdata;
          out_valid <= 1'b1;
          out_sop <= 1'b0;
          csum <= csum ^ rdata;
          cnt <= cnt + 16'd1;
          if (cnt == len - 16'd1) state <= CSUM;
        end
        CSUM: if (adv) begin
          // second visit with eop set means the checksum byte has just been taken
          if (out_eop) begin
            out_eop <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end else begin
            out_data <= csum;
            out_valid <= 1'b1;
            out_eop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_framer.sv
// tb_capture_framer: scoreboard bench for capture_framer
module tb_capture_framer;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] in_data, in_flags, out_data;
  logic [63:0] in_timestamp;
  logic in_valid, in_ready, out_valid, out_ready, out_sop, out_eop, busy;
  logic [15:0] drop_count;
  int checks = 0, failures = 0, popped = 0, exp_drop = 0;
  bit rand_ready = 1'b0;
  logic [9:0] exp_q[$];
  logic [7:0] rec_q[$];
  logic [63:0] rec_ts;
  logic [7:0] rec_flags;
  bit stall = 1'b0;
  logic [7:0] h_data;
  logic h_sop, h_eop;
  logic [9:0] e;

  capture_framer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_timestamp(in_timestamp), .in_flags(in_flags), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, h_data);
      check("hold_sop", out_sop, h_sop);
      check("hold_eop", out_eop, h_eop);
    end
    stall = out_valid && !out_ready;
    h_data = out_data;
    h_sop = out_sop;
    h_eop = out_eop;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_byte", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("data", out_data, e[7:0]);
        check("sop", out_sop, e[9]);
        check("eop", out_eop, e[8]);
        popped++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] f, input logic [63:0] t);
    int n = 0;
    in_data = d;
    in_flags = f;
    in_timestamp = t;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_record();
    int n, m;
    logic [7:0] b[$];
    logic [7:0] c, f;
    n = rec_q.size();
    m = n > 256 ? 256 : n;
    b = {};
    b.push_back(8'hA5);
    b.push_back({n > 256, rec_flags[6:0]});
    for (int i = 0; i < 8; i++) b.push_back(rec_ts[8*i +: 8]);
    b.push_back(m[7:0]);
    b.push_back(m[15:8]);
    for (int i = 0; i < m; i++) b.push_back(rec_q[i]);
    c = 8'h00;
    for (int i = 1; i < b.size(); i++) c ^= b[i];
    b.push_back(c);
    for (int i = 0; i < b.size(); i++) exp_q.push_back({i == 0, i == b.size() - 1, b[i]});
    for (int i = 0; i < n; i++) begin
      f = (i == 0 ? rec_flags : 8'h00) | (i == n - 1 ? 8'h02 : 8'h00);
      send(rec_q[i], f, i == 0 ? rec_ts : {$urandom, $urandom});
    end
    check("busy_after_eop", busy, 1);
    repeat (2) @(posedge clk);
    #1 check("first_byte_latency", out_valid, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", n < 5000, 1);
    check("queue_empty", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_flags = '0;
    in_timestamp = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_data", out_data, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_rise", in_ready, 1);

    rec_q = {8'h2D, 8'h11, 8'h22};
    rec_ts = 64'h0102030405060708;
    rec_flags = 8'h01;
    send_record();
    wait_idle();
    check("drop_basic", drop_count, exp_drop);

    rand_ready = 1'b1;
    send_record();
    wait_idle();
    rand_ready = 1'b0;

    rec_q = {};
    for (int i = 0; i < 300; i++) rec_q.push_back(8'($urandom));
    rec_ts = {$urandom, $urandom};
    rec_flags = 8'h71;
    send_record();
    wait_idle();
    check("drop_trunc", drop_count, exp_drop);

    rec_q = {8'hC3};
    rec_ts = 64'hDEADBEEF_00C0FFEE;
    rec_flags = 8'h07;
    send_record();
    wait_idle();

    send(8'h99, 8'h00, 64'h1);
    exp_drop++;
    check("drop_idle", drop_count, exp_drop);
    send(8'h55, 8'h01, 64'h2);
    send(8'h66, 8'h00, 64'h3);
    rec_q = {8'h3C, 8'h4D, 8'h5E, 8'h6F};
    rec_ts = 64'h1111_2222_3333_4444;
    rec_flags = 8'h0D;
    exp_drop++;
    send_record();
    wait_idle();
    check("drop_abort", drop_count, exp_drop);

    rec_q = {};
    for (int i = 0; i < 40; i++) rec_q.push_back(8'(i * 7 + 1));
    rec_ts = 64'hA0A1A2A3A4A5A6A7;
    rec_flags = 8'h01;
    begin
      int p0 = popped;
      int n = 0;
      send_record();
      while (popped < p0 + 20 && n < 1000) begin
        @(posedge clk);
        n++;
      end
      check("reach_pay", n < 1000, 1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_eop", out_eop, 0);
    check("midrst_busy", busy, 0);
    check("midrst_drop", drop_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("midrst_in_ready", in_ready, 1);
    rec_q = {8'h2D, 8'h11, 8'h22};
    rec_ts = 64'h0102030405060708;
    rec_flags = 8'h01;
    send_record();
    wait_idle();
    check("drop_after_reset", drop_count, exp_drop);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
